// File: rtl/i2c_target_engine_if.sv
// Upstream side of the I2C target engine: received bytes, read-byte
// requests and bus-state pulses exchanged with the register file.
`timescale 1ns/100ps
interface i2c_target_engine_if;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_first_o;
    logic       tx_req_o;
    logic [7:0] tx_data_i;
    logic       start_o;
    logic       stop_o;
    logic       busy_o;

    modport master (
        output rx_data_o,
        output rx_valid_o,
        output rx_first_o,
        output tx_req_o,
        output start_o,
        output stop_o,
        output busy_o,
        input  tx_data_i
    );

    modport slave (
        input  rx_data_o,
        input  rx_valid_o,
        input  rx_first_o,
        input  tx_req_o,
        input  start_o,
        input  stop_o,
        input  busy_o,
        output tx_data_i
    );
endinterface

// File: rtl/i2c_target_engine.sv
// Byte-level I2C target: START/STOP decode, address match with ACK,
// write-byte delivery and read-byte serialisation. SDA is open drain.
`timescale 1ns/100ps
module i2c_target_engine #(
    parameter logic [6:0]  TARGET_ADDR = 7'h40,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  scl_i,
    inout  wire                   sda_io,
    i2c_target_engine_if.master   bus
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        READ_ACK,
        IGNORE
    } state_e;

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;

    state_e     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [3:0] cnt_q, cnt_d;
    logic       oe_q, oe_d;
    logic       rw_q, rw_d;
    logic       first_q, first_d;
    logic       busy_q, busy_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_first_q, rx_first_d;
    logic       tx_req_q, tx_req_d;
    logic       start_q, start_d;
    logic       stop_q, stop_d;

    logic scl_s;
    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & ~sda_prev_q & sda_s;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        oe_d       = oe_q;
        rw_d       = rw_q;
        first_d    = first_q;
        busy_d     = busy_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_first_d = 1'b0;
        tx_req_d   = 1'b0;
        start_d    = 1'b0;
        stop_d     = 1'b0;

        if (start_det) begin
            oe_d    = 1'b0;
            cnt_d   = 4'd0;
            start_d = 1'b1;
            busy_d  = 1'b1;
            state_d = ADDR;
        end else if (stop_det) begin
            oe_d    = 1'b0;
            stop_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: ;
                ADDR: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_s};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        cnt_d = 4'd0;
                        rw_d  = shift_q[0];
                        if (shift_q[7:1] == TARGET_ADDR) begin
                            oe_d    = 1'b1;
                            state_d = ADDR_ACK;
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_rise) begin
                        tx_req_d = rw_q;
                    end else if (scl_fall) begin
                        if (rw_q) begin
                            shift_d = bus.tx_data_i;
                            oe_d    = ~bus.tx_data_i[7];
                            cnt_d   = 4'd1;
                            state_d = READ;
                        end else begin
                            oe_d    = 1'b0;
                            first_d = 1'b1;
                            cnt_d   = 4'd0;
                            state_d = WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_s};
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            rx_data_d  = {shift_q[6:0], sda_s};
                            rx_valid_d = 1'b1;
                            rx_first_d = first_q;
                            first_d    = 1'b0;
                        end
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        oe_d    = 1'b1;
                        cnt_d   = 4'd0;
                        state_d = WRITE_ACK;
                    end
                end
                WRITE_ACK: begin
                    if (scl_fall) begin
                        oe_d    = 1'b0;
                        state_d = WRITE;
                    end
                end
                READ: begin
                    if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            oe_d    = 1'b0;
                            cnt_d   = 4'd0;
                            state_d = READ_ACK;
                        end else begin
                            oe_d    = ~shift_q[6];
                            shift_d = {shift_q[6:0], 1'b0};
                            cnt_d   = cnt_q + 4'd1;
                        end
                    end
                end
                READ_ACK: begin
                    // cnt_q marks that the controller ACKed on this clock
                    if (scl_rise) begin
                        if (sda_s) begin
                            state_d = IGNORE;
                        end else begin
                            tx_req_d = 1'b1;
                            cnt_d    = 4'd1;
                        end
                    end else if (scl_fall && cnt_q != 4'd0) begin
                        shift_d = bus.tx_data_i;
                        oe_d    = ~bus.tx_data_i[7];
                        cnt_d   = 4'd1;
                        state_d = READ;
                    end
                end
                IGNORE: oe_d = 1'b0;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= IDLE;
            shift_q    <= 8'h00;
            cnt_q      <= 4'd0;
            oe_q       <= 1'b0;
            rw_q       <= 1'b0;
            first_q    <= 1'b0;
            busy_q     <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_first_q <= 1'b0;
            tx_req_q   <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_io};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            oe_q       <= oe_d;
            rw_q       <= rw_d;
            first_q    <= first_d;
            busy_q     <= busy_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_first_q <= rx_first_d;
            tx_req_q   <= tx_req_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
        end
    end

    assign sda_io         = oe_q ? 1'b0 : 1'bz;
    assign bus.rx_data_o  = rx_data_q;
    assign bus.rx_valid_o = rx_valid_q;
    assign bus.rx_first_o = rx_first_q;
    assign bus.tx_req_o   = tx_req_q;
    assign bus.start_o    = start_q;
    assign bus.stop_o     = stop_q;
    assign bus.busy_o     = busy_q;

endmodule

// File: doc/i2c_target_engine.md
Name: i2c_target_engine

Overview:
- Byte-level I2C responder (target) for the PCA9685-compatible register front end.
- Watches SCL and drives SDA strictly as open drain: 1'bz or 1'b0, never 1'b1.
- Detects START, repeated START and STOP, matches the 7-bit address and ACKs it.
- Delivers written bytes upstream and serialises read bytes supplied by the register file. No clock stretching.

Parameters:
- TARGET_ADDR, 7'h40, 7-bit address this target ACKs.
- SYNC_STAGES, 2, synchroniser depth on scl_i and sda_io (minimum 2).

Ports:
- clk_i  in  1  system clock; must be at least 16x the SCL frequency.
- rst_ni  in  1  asynchronous active-low reset.
- scl_i  in  1  I2C clock from the bus; input only.
- sda_io  inout  1  I2C data; driven only 1'bz or 1'b0.
- rx_data_o  out  8  last byte received in a write transfer.
- rx_valid_o  out  1  one-cycle pulse; rx_data_o is new.
- rx_first_o  out  1  qualifies rx_valid_o; first data byte after the address (register pointer).
- tx_req_o  out  1  one-cycle pulse; upstream must present the next read byte.
- tx_data_i  in  8  read byte; sampled at the SCL falling edge following tx_req_o.
- start_o  out  1  one-cycle pulse on START or repeated START.
- stop_o  out  1  one-cycle pulse on STOP.
- busy_o  out  1  high from START until STOP.

Behaviour:
- Reset: asynchronous, active-low rst_ni; clock clk_i.
- Values under reset: sda_io released (z), state IDLE, all pulse outputs 0, rx_data_o 8'h00, busy_o 0, bit counter 0, synchroniser flops preset to 1.
- Sampling: scl/sda pass through SYNC_STAGES flops. Edges are detected by comparing the synchronised value with its previous value, so decode latency is SYNC_STAGES+1 clk_i cycles.
- The sda_io value used for decode is the pin value (bus wired-AND), including our own drive.
- START: synced SDA falls while synced SCL is high. STOP: synced SDA rises while synced SCL is high.
- START and STOP take priority over any SCL edge detected in the same cycle.
- START in any state: release SDA, clear bit counter, pulse start_o, set busy_o, go to ADDR.
- STOP in any state: release SDA, pulse stop_o, clear busy_o, go to IDLE.
- Data bits are MSB first and sampled on the SCL rising edge. The target changes SDA only on the SCL falling edge.
- IDLE: ignore SCL.
- ADDR: shift 8 bits.
  - On the 8th falling edge, if bits[7:1]==TARGET_ADDR: pull SDA low and go to ADDR_ACK.
  - Otherwise go to IGNORE with SDA released.
- ADDR_ACK: on the next falling edge release SDA.
  - R/W=0: go to WRITE and set the first-byte flag.
  - R/W=1: go to READ, load tx_data_i into the shifter, and drive its MSB (0 = pull low, 1 = release).
  - tx_req_o pulses on the rising edge of the ACK clock when R/W=1.
- WRITE: shift 8 bits.
  - The cycle after the 8th rising-edge sample: rx_data_o updates, rx_valid_o pulses, and rx_first_o equals the first-byte flag (then cleared).
  - On the 8th falling edge pull SDA low; go to WRITE_ACK.
- WRITE_ACK: on the next falling edge release SDA and return to WRITE. Byte count is unbounded.
- READ: on each falling edge present the next bit. After the 8th bit's falling edge release SDA and go to READ_ACK.
- READ_ACK: sample the controller on the 9th rising edge.
  - SDA low (ACK): pulse tx_req_o. At the following falling edge load tx_data_i, drive its MSB, and go to READ.
  - SDA high (NACK): go to IGNORE with SDA released.
- IGNORE: SDA released; leave only on START or STOP.
- STOP or START mid-byte discards the partial byte: no rx_valid_o pulse.
- Reset mid-operation releases SDA immediately and asynchronously.
- General call (address 0) is not supported unless TARGET_ADDR==0.
- The target never holds SCL.

Test Plan:
- Bench uses a pull-up model on SDA (wired-AND of bench driver and DUT) and 100 kHz SCL with clk_i = 27 MHz.
- Write S,0x80,0x06,0xA5,P -> ACK on all three bytes; rx_valid_o pulses twice (0x06 with rx_first_o=1, 0xA5 with rx_first_o=0); start_o and stop_o pulse once each; busy_o high between them.
- Write S,0x82,0x11,P (address 0x41) -> SDA never pulled low; no rx_valid_o; stop_o pulses; the next transfer to 0x40 is ACKed.
- Read S,0x81, tx_data_i=0x3C then 0xF0, controller ACK then NACK, P -> SDA bits 0x3C then 0xF0; exactly two tx_req_o pulses; SDA released after NACK.
- Write S,0x80,0x06, Sr,0x81, read one byte NACK, P -> rx_valid_o once with rx_first_o=1; start_o twice; read byte correct.
- Mid-byte abort: S,0x80, four bits of 0xFF, P -> no rx_valid_o; state IDLE; SDA released.
- Reset mid-transfer: assert rst_ni low while the DUT is pulling SDA low during ACK -> SDA reads 1 (pull-up) within the same cycle; all outputs at reset values; a following S,0x80 is ACKed.
